lane_permute_reg: RTL and testbench



---
 rtl/lane_permute_pkg.sv | 17 +
 rtl/lane_permute_net.sv | 34 +++
 rtl/lane_permute_reg.sv | 136 +++++++++++++
 tb/tb_lane_permute_reg.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lane_permute_pkg.sv
// Shared encodings for the lane permutation register bank.
package lane_permute_pkg;

  // Permutation mode encodings, as driven on the mode port
  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_SWAP   = 2'd1;
  localparam logic [1:0] MODE_ROT_UP = 2'd2;
  localparam logic [1:0] MODE_ROT_DN = 2'd3;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/lane_permute_net.sv
// Combinational permutation network: maps the current lane vector and a mode
// to the lane vector after one permutation step. Every output lane reads only
// input lanes, so all lanes update from pre-step values.
module lane_permute_net
  import lane_permute_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2
) (
  input  logic [LANES*WIDTH-1:0] lanes_in,
  input  logic [1:0]             mode,
  output logic [LANES*WIDTH-1:0] lanes_out
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // Source lane index for each permutation, resolved at elaboration
    localparam int SrcUp = (i == 0) ? int'(LANES) - 1 : i - 1;
    localparam int SrcDn = (i == int'(LANES) - 1) ? 0 : i + 1;
    // Even lanes pair with the lane above; an unpaired top lane holds
    localparam int SrcSw = (i % 2 == 0) ? ((i + 1 < int'(LANES)) ? i + 1 : i) : i - 1;

    // Select the source lane for this output lane
    always_comb begin
      lanes_out[i*WIDTH +: WIDTH] = lanes_in[i*WIDTH +: WIDTH];
      case (mode)
        MODE_SWAP:   lanes_out[i*WIDTH +: WIDTH] = lanes_in[SrcSw*WIDTH +: WIDTH];
        MODE_ROT_UP: lanes_out[i*WIDTH +: WIDTH] = lanes_in[SrcUp*WIDTH +: WIDTH];
        MODE_ROT_DN: lanes_out[i*WIDTH +: WIDTH] = lanes_in[SrcDn*WIDTH +: WIDTH];
        default:     lanes_out[i*WIDTH +: WIDTH] = lanes_in[i*WIDTH +: WIDTH];
      endcase
    end
  end

endmodule

// File: rtl/lane_permute_reg.sv
// Bank of LANES registers, WIDTH bits each, permuted together once per clock
// for a programmed number of steps (swap pairs, rotate up, rotate down, hold).
// Optional feature macro: LANE_PERMUTE_XSUM_EN adds an XOR checksum of the
// lanes (xsum) and a sticky flag (xsum_err) raised if the lanes ever disagree
// with it.
module lane_permute_reg
  import lane_permute_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [LANES*WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [CNT_W-1:0]       steps,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       remaining,
  output logic [LANES*WIDTH-1:0] data_out
`ifdef LANE_PERMUTE_XSUM_EN
  ,
  output logic [WIDTH-1:0]       xsum,
  output logic                   xsum_err
`endif
);

  state_e                 state_q;
  logic [1:0]             mode_q;
  logic [CNT_W-1:0]       remaining_q;
  logic [LANES*WIDTH-1:0] lanes_q;
  logic [LANES*WIDTH-1:0] lanes_next;
  logic                   busy_q;
  logic                   done_q;

  lane_permute_net #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_net (
    .lanes_in  (lanes_q),
    .mode      (mode_q),
    .lanes_out (lanes_next)
  );

  // Control FSM, step counter and lane registers; busy/done are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_HOLD;
      remaining_q <= '0;
      lanes_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            // Load takes priority; a coincident start is dropped
            lanes_q <= load_data;
          end else if (start) begin
            mode_q      <= mode;
            remaining_q <= steps;
            if (steps != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          lanes_q     <= lanes_next;
          remaining_q <= remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;
  assign data_out  = lanes_q;

`ifdef LANE_PERMUTE_XSUM_EN
  logic [WIDTH-1:0] xsum_q;
  logic             xsum_err_q;
  logic [WIDTH-1:0] lanes_fold;
  logic [WIDTH-1:0] load_fold;

  // XOR-fold of the live lanes and of the incoming load vector
  always_comb begin
    lanes_fold = '0;
    load_fold  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lanes_fold = lanes_fold ^ lanes_q[i*WIDTH +: WIDTH];
      load_fold  = load_fold ^ load_data[i*WIDTH +: WIDTH];
    end
  end

  // Checksum tracks loads only; any permutation must leave the fold unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      xsum_q     <= '0;
      xsum_err_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && load) begin
        xsum_q <= load_fold;
      end
      if (lanes_fold != xsum_q) begin
        xsum_err_q <= 1'b1;
      end
    end
  end

  assign xsum     = xsum_q;
  assign xsum_err = xsum_err_q;
`endif

endmodule

// File: tb/tb_lane_permute_reg.sv
// Directed bench for lane_permute_reg: three instances (2, 4 and 3 lanes)
// share clock, reset, mode and steps; each has its own load/start strobes.
module tb_lane_permute_reg;
  import lane_permute_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] steps;
  logic [2:0] ld;
  logic [2:0] st;

  logic [15:0] d2, q2;
  logic [31:0] d4, q4;
  logic [23:0] d3, q3;
  logic        busy2, busy4, busy3;
  logic        done2, done4, done3;
  logic [7:0]  rem2, rem4, rem3;
`ifdef LANE_PERMUTE_XSUM_EN
  logic [7:0] xs2, xs4, xs3;
  logic       xe2, xe4, xe3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lane_permute_reg #(.WIDTH(8), .LANES(2), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .load(ld[0]), .load_data(d2), .start(st[0]),
    .mode(mode), .steps(steps), .busy(busy2), .done(done2), .remaining(rem2),
    .data_out(q2)
`ifdef LANE_PERMUTE_XSUM_EN
    , .xsum(xs2), .xsum_err(xe2)
`endif
  );

  lane_permute_reg #(.WIDTH(8), .LANES(4), .CNT_W(8)) u4 (
    .clk(clk), .reset(reset), .load(ld[1]), .load_data(d4), .start(st[1]),
    .mode(mode), .steps(steps), .busy(busy4), .done(done4), .remaining(rem4),
    .data_out(q4)
`ifdef LANE_PERMUTE_XSUM_EN
    , .xsum(xs4), .xsum_err(xe4)
`endif
  );

  lane_permute_reg #(.WIDTH(8), .LANES(3), .CNT_W(8)) u3 (
    .clk(clk), .reset(reset), .load(ld[2]), .load_data(d3), .start(st[2]),
    .mode(mode), .steps(steps), .busy(busy3), .done(done3), .remaining(rem3),
    .data_out(q3)
`ifdef LANE_PERMUTE_XSUM_EN
    , .xsum(xs3), .xsum_err(xe3)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1; ld = '0; st = '0; mode = MODE_HOLD; steps = '0;
    d2 = '0; d4 = '0; d3 = '0;
    tick(); tick();
    check("rst_q2", q2, 0);
    check("rst_busy2", busy2, 0);
    check("rst_done2", done2, 0);
    check("rst_rem2", rem2, 0);
    check("rst_q4", q4, 0);
    check("rst_q3", q3, 0);
    reset = 1'b0;

    // 2 lanes: SWAP x3 on lane1=01, lane0=00
    d2 = 16'h0100; ld = 3'b001; tick(); ld = '0;
    check("ld_q2", q2, 16'h0100);
    mode = MODE_SWAP; steps = 8'd3; st = 3'b001; tick(); st = '0;
    check("swap_e0_busy", busy2, 1);
    check("swap_e0_rem", rem2, 3);
    check("swap_e0_q", q2, 16'h0100);
    tick(); check("swap_e1_q", q2, 16'h0001); check("swap_e1_rem", rem2, 2);
    tick(); check("swap_e2_q", q2, 16'h0100);
    tick(); check("swap_e3_q", q2, 16'h0001);
    check("swap_e3_done", done2, 1);
    check("swap_e3_busy", busy2, 0);
    tick(); check("swap_done_clr", done2, 0);

    // 4 lanes: ROT_UP x5 on A,B,C,D then ROT_DN x1
    d4 = 32'h44332211; ld = 3'b010; tick(); ld = '0;
    mode = MODE_ROT_UP; steps = 8'd5; st = 3'b010; tick(); st = '0;
    mode = MODE_SWAP; steps = 8'd9;  // changes after start must not matter
    check("rotup_e0_rem", rem4, 5);
    repeat (4) tick();
    check("rotup_e4_rem", rem4, 1);
    check("rotup_e4_busy", busy4, 1);
    tick();
    check("rotup_q", q4, 32'h33221144);
    check("rotup_done", done4, 1);
    tick();
    mode = MODE_ROT_DN; steps = 8'd1; st = 3'b010; tick(); st = '0;
    tick();
    check("rotdn_q", q4, 32'h44332211);
    check("rotdn_done", done4, 1);
    tick();

    // 3 lanes: SWAP x1, top lane holds
    d3 = 24'hccbbaa; ld = 3'b100; tick(); ld = '0;
    mode = MODE_SWAP; steps = 8'd1; st = 3'b100; tick(); st = '0;
    tick();
    check("swap3_q", q3, 24'hccaabb);
    check("swap3_done", done3, 1);
    tick();

    // steps=0 then HOLD x4 on the 2-lane instance
    mode = MODE_SWAP; steps = 8'd0; st = 3'b001; tick(); st = '0;
    check("zero_busy", busy2, 0);
    check("zero_done", done2, 1);
    check("zero_q", q2, 16'h0001);
    tick(); check("zero_done_clr", done2, 0);
    mode = MODE_HOLD; steps = 8'd4; st = 3'b001; tick(); st = '0;
    n = 0;
    while (busy2 && n < 20) begin
      n++;
      tick();
    end
    check("hold_busy_cycles", n, 4);
    check("hold_done", done2, 1);
    check("hold_q", q2, 16'h0001);
    tick();

    // 4 lanes: ROT_UP x6, ignored strobes in RUN, reset after E2
    mode = MODE_ROT_UP; steps = 8'd6; st = 3'b010; tick(); st = '0;
    tick();
    d4 = 32'hdeadbeef; ld = 3'b010; st = 3'b010; steps = 8'd1;
    tick();
    ld = '0; st = '0;
    check("ign_rem", rem4, 4);
    check("ign_q", q4, 32'h22114433);
    check("ign_busy", busy4, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort_q", q4, 0);
    check("abort_busy", busy4, 0);
    check("abort_rem", rem4, 0);
    check("abort_done", done4, 0);
    tick(); check("abort_no_done", done4, 0);

    // load and start on the same IDLE edge: load wins
    d2 = 16'h5a3c; mode = MODE_SWAP; steps = 8'd2; ld = 3'b001; st = 3'b001;
    tick(); ld = '0; st = '0;
    check("ldst_q", q2, 16'h5a3c);
    check("ldst_busy", busy2, 0);
    tick();
    check("ldst_busy2", busy2, 0);
    check("ldst_done", done2, 0);

`ifdef LANE_PERMUTE_XSUM_EN
    d4 = 32'h0f1e2d3c; ld = 3'b010; tick(); ld = '0;
    for (int i = 0; i < 255; i++) begin
      mode = 2'($urandom_range(0, 3)); steps = 8'd1; st = 3'b010;
      tick(); st = '0;
      tick(); tick();
    end
    check("xsum_val", xs4, 8'h0f ^ 8'h1e ^ 8'h2d ^ 8'h3c);
    check("xsum_err", xe4, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
